cpu_bus_serializer: RTL and testbench



---
 rtl/cpu_bus_pkg.sv | 28 ++
 rtl/bus_lane_mux.sv | 28 ++
 rtl/cpu_bus_serializer.sv | 166 ++++++++++++++++
 tb/tb_cpu_bus_serializer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU-to-pad bus serializer.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CMD,
        ST_TURN,
        ST_DATA,
        ST_RESP
    } state_e;

    localparam int CMD_WE_BIT    = 0;
    localparam int CMD_FRAME_BIT = 1;

    function automatic bit widths_ok(input int addr_w, input int data_w, input int pin_w);
        return (pin_w >= 2) && (addr_w > 0) && (data_w > 0) &&
               (addr_w % pin_w == 0) && (data_w % pin_w == 0);
    endfunction

    // Beat counter width: enough for max(AB, DB) beats, never narrower than 1 bit.
    function automatic int beat_cnt_w(input int ab, input int db);
        int m;
        m = (ab > db) ? ab : db;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bus_lane_mux.sv
// Lane selector: reads PIN_W slice `sel` of a word, and returns the word with
// that slice replaced by `wr_slice`.
module bus_lane_mux #(
    parameter int W     = 32,
    parameter int PIN_W = 8,
    parameter int CW    = 2
) (
    input  logic [W-1:0]     word,
    input  logic [CW-1:0]    sel,
    output logic [PIN_W-1:0] slice,
    input  logic [PIN_W-1:0] wr_slice,
    output logic [W-1:0]     merged
);
    localparam int N = W / PIN_W;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        slice  = '0;
        merged = word;
        for (int i = 0; i < N; i++) begin
            if (sel == CW'(i)) begin
                slice                      = word[i*PIN_W +: PIN_W];
                merged[i*PIN_W +: PIN_W]   = wr_slice;
            end
        end
    end

endmodule

// File: rtl/cpu_bus_serializer.sv
// Frames CPU requests as address/command/turnaround/data beats on the pad bus.
// Optional BUS_WAIT_EN: pad_wait_i stalls DATA beats.
module cpu_bus_serializer
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PIN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [PIN_W-1:0]  pad_addr_o,
    output logic [PIN_W-1:0]  pad_data_o,
    output logic [PIN_W-1:0]  pad_data_oe,
    input  logic [PIN_W-1:0]  pad_data_i,
    input  logic              pad_wait_i
);
    localparam int AB = ADDR_W / PIN_W;
    localparam int DB = DATA_W / PIN_W;
    localparam int CW = beat_cnt_w(AB, DB);
    localparam logic [CW-1:0] AB_LAST = CW'(AB - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

    if (!widths_ok(ADDR_W, DATA_W, PIN_W)) begin : g_bad_widths
        $error("cpu_bus_serializer: ADDR_W and DATA_W must be multiples of PIN_W, PIN_W >= 2");
    end

    state_e              state, state_d;
    logic [CW-1:0]       beat, beat_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rx_q;
    logic                accept, stall, rx_sample;

    logic [ADDR_W-1:0]   addr_word, unused_addr_rx;
    logic [PIN_W-1:0]    addr_slice;
    logic [DATA_W-1:0]   data_word, rx_merged;
    logic [CW-1:0]       data_sel;
    logic [PIN_W-1:0]    data_slice, cmd_word;
    logic [PIN_W-1:0]    pad_addr_d, pad_data_d, pad_data_oe_d;

`ifdef BUS_WAIT_EN
    assign stall = (state == ST_DATA) && pad_wait_i;
`else
    logic unused_wait;
    assign unused_wait = pad_wait_i;
    assign stall       = 1'b0;
`endif

    assign accept    = req_valid && req_ready;
    assign rx_sample = (state == ST_DATA) && !we_q && !stall;

    always_comb begin
        state_d = state;
        beat_d  = beat;
        unique case (state)
            ST_IDLE: if (accept) begin
                state_d = ST_ADDR;
                beat_d  = '0;
            end
            ST_ADDR: begin
                if (beat == AB_LAST) begin
                    state_d = ST_CMD;
                    beat_d  = '0;
                end else begin
                    beat_d = beat + 1'b1;
                end
            end
            ST_CMD: begin
                state_d = we_q ? ST_DATA : ST_TURN;
                beat_d  = '0;
            end
            ST_TURN: state_d = ST_DATA;
            ST_DATA: if (!stall) begin
                if (beat == DB_LAST) begin
                    state_d = ST_RESP;
                    beat_d  = '0;
                end else begin
                    beat_d = beat + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so the accept edge already
    // presents address beat 0 before addr_q has been loaded.
    assign addr_word = accept ? req_addr : addr_q;
    assign data_word = we_q ? wdata_q : rx_q;
    assign data_sel  = we_q ? beat_d : beat;

    bus_lane_mux #(.W(ADDR_W), .PIN_W(PIN_W), .CW(CW)) u_addr_lane (
        .word     (addr_word),
        .sel      (beat_d),
        .slice    (addr_slice),
        .wr_slice ('0),
        .merged   (unused_addr_rx)
    );

    bus_lane_mux #(.W(DATA_W), .PIN_W(PIN_W), .CW(CW)) u_data_lane (
        .word     (data_word),
        .sel      (data_sel),
        .slice    (data_slice),
        .wr_slice (pad_data_i),
        .merged   (rx_merged)
    );

    always_comb begin
        cmd_word                = '0;
        cmd_word[CMD_FRAME_BIT] = 1'b1;
        cmd_word[CMD_WE_BIT]    = we_q;
        pad_addr_d              = '0;
        pad_data_d              = '0;
        pad_data_oe_d           = '0;
        if (state_d == ST_ADDR) pad_addr_d = addr_slice;
        if (state_d == ST_CMD)  pad_addr_d = cmd_word;
        if ((state_d == ST_DATA) && we_q) begin
            pad_data_d    = data_slice;
            pad_data_oe_d = '1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            beat        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rx_q        <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            pad_addr_o  <= '0;
            pad_data_o  <= '0;
            pad_data_oe <= '0;
        end else begin
            state       <= state_d;
            beat        <= beat_d;
            req_ready   <= (state_d == ST_IDLE);
            rsp_valid   <= (state_d == ST_RESP);
            pad_addr_o  <= pad_addr_d;
            pad_data_o  <= pad_data_d;
            pad_data_oe <= pad_data_oe_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (rx_sample) begin
                rx_q <= rx_merged;
                if (state_d == ST_RESP) rsp_rdata <= rx_merged;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_serializer.sv
// Self-checking bench for cpu_bus_serializer (default 32/32/8 plus a 16/16/8 instance).
module tb_cpu_bus_serializer;
    localparam int AB = 4;
    localparam int DB = 4;
`ifdef BUS_WAIT_EN
    localparam bit WAIT_ON = 1'b1;
`else
    localparam bit WAIT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic [7:0]  pad_addr_o, pad_data_o, pad_data_oe;
    logic [7:0]  pad_data_i = '0;
    logic        pad_wait_i = 1'b0;

    logic        r16_valid = 1'b0, r16_we = 1'b0, r16_ready, r16_rsp;
    logic [15:0] r16_addr = '0, r16_wdata = '0, r16_rdata;
    logic [7:0]  r16_pa, r16_pd, r16_oe;
    logic [7:0]  r16_pin = 8'h00;
    logic        r16_wait = 1'b0;

    always #5 clk = ~clk;

    cpu_bus_serializer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .pad_addr_o(pad_addr_o), .pad_data_o(pad_data_o), .pad_data_oe(pad_data_oe),
        .pad_data_i(pad_data_i), .pad_wait_i(pad_wait_i)
    );

    cpu_bus_serializer #(.ADDR_W(16), .DATA_W(16), .PIN_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r16_valid), .req_ready(r16_ready), .req_we(r16_we),
        .req_addr(r16_addr), .req_wdata(r16_wdata),
        .rsp_valid(r16_rsp), .rsp_rdata(r16_rdata),
        .pad_addr_o(r16_pa), .pad_data_o(r16_pd), .pad_data_oe(r16_oe),
        .pad_data_i(r16_pin), .pad_wait_i(r16_wait)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: one record per bus cycle, derived from the framing rules.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] oe;
        logic       rv;
        logic [7:0] rx;
        logic       wt;
    } cyc_t;
    cyc_t exp_q[$];

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c    = '0;
        c.rx = 8'($urandom);
        c.wt = 1'($urandom);
        return c;
    endfunction

    function automatic void build(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rword, input int wbeat, input int wlen);
        cyc_t c;
        exp_q.delete();
        for (int k = 0; k < AB; k++) begin
            c = idle_cyc();
            c.a = addr[8*k +: 8];
            exp_q.push_back(c);
        end
        c = idle_cyc();
        c.a = {6'b0, 1'b1, we};
        exp_q.push_back(c);
        if (!we) exp_q.push_back(idle_cyc());
        for (int k = 0; k < DB; k++) begin
            c    = idle_cyc();
            c.d  = we ? wdata[8*k +: 8] : 8'h00;
            c.oe = we ? 8'hFF : 8'h00;
            if (WAIT_ON && k == wbeat) begin
                for (int s = 0; s < wlen; s++) begin
                    c.wt = 1'b1;
                    c.rx = 8'($urandom);
                    exp_q.push_back(c);
                end
            end
            c.rx = rword[8*k +: 8];
            c.wt = WAIT_ON ? 1'b0 : 1'($urandom);
            exp_q.push_back(c);
        end
        c = idle_cyc();
        c.rv = 1'b1;
        exp_q.push_back(c);
    endfunction

    // Called at a negedge; returns right after the accept edge.
    task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
    endtask

    // Walks the frame cycle by cycle against the reference; nv/nwe/naddr/nwdata
    // are what the CPU presents on the request port during the frame.
    task automatic follow(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rword, input int wbeat, input int wlen,
                          input int exp_lat, input string nm, input logic nv, input logic nwe,
                          input logic [31:0] naddr, input logic [31:0] nwdata);
        int lat = -1;
        logic [31:0] exp_rd;
        build(we, addr, wdata, rword, wbeat, wlen);
        @(negedge clk);
        req_valid = nv;
        req_we    = nwe;
        req_addr  = naddr;
        req_wdata = nwdata;
        foreach (exp_q[c]) begin
            exp_rd = (exp_q[c].rv && !we) ? rword : last_rdata;
            check($sformatf("%s_c%0d", nm, c + 1),
                  64'({pad_addr_o, pad_data_o, pad_data_oe, rsp_valid, req_ready, rsp_rdata}),
                  64'({exp_q[c].a, exp_q[c].d, exp_q[c].oe, exp_q[c].rv, 1'b0, exp_rd}));
            if (rsp_valid && lat < 0) lat = c + 1;
            pad_data_i = exp_q[c].rx;
            pad_wait_i = exp_q[c].wt;
            @(negedge clk);
        end
        if (!we) last_rdata = rword;
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_end"}, 64'({rsp_valid, req_ready, rsp_rdata}), 64'({1'b0, 1'b1, last_rdata}));
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rword, input int wbeat, input int wlen,
                           input int exp_lat, input string nm);
        start_req(we, addr, wdata);
        follow(we, addr, wdata, rword, wbeat, wlen, exp_lat, nm,
               1'b0, 1'($urandom), $urandom, $urandom);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          wbeat;
        int          wlen;
        int          lat;
        string       name;
    } vec_t;
    vec_t vecs[6];

    logic [24:0] exp16[6];

    initial begin
        logic        we;
        int          wl;
        bit          seen;

        vecs[0] = '{1'b1, 32'hDEADBEEF, 32'h12345678, 32'h0,        0, 0, 10, "wr_deadbeef"};
        vecs[1] = '{1'b0, 32'h00000010, 32'hCAFEF00D, 32'hDDCCBBAA, 0, 0, 11, "rd_10"};
        vecs[2] = '{1'b0, 32'h80000001, 32'h0,        32'h01020304, 1, 3, WAIT_ON ? 14 : 11, "rd_wait_b1"};
        vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        3, 2, WAIT_ON ? 12 : 10, "wr_wait_b3"};
        vecs[4] = '{1'b0, 32'h00000000, 32'h0,        32'h00000000, 0, 0, 11, "rd_zero"};
        vecs[5] = '{1'b1, 32'h00FF00FF, 32'hA5A55A5A, 32'h0,        0, 1, WAIT_ON ? 11 : 10, "wr_wait_b0"};

        exp16 = '{{8'hC3, 8'h00, 8'h00, 1'b0}, {8'hA5, 8'h00, 8'h00, 1'b0},
                  {8'h03, 8'h00, 8'h00, 1'b0}, {8'h00, 8'h1E, 8'hFF, 1'b0},
                  {8'h00, 8'h0F, 8'hFF, 1'b0}, {8'h00, 8'h00, 8'h00, 1'b1}};

        repeat (3) @(negedge clk);
        check("reset_state",
              64'({pad_addr_o, pad_data_o, pad_data_oe, rsp_valid, req_ready, rsp_rdata}),
              64'({8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 32'h0}));
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rword,
                    vecs[i].wbeat, vecs[i].wlen, vecs[i].lat, vecs[i].name);

        // Back-to-back: req_valid stays high; the read is only taken after RESP.
        start_req(1'b1, 32'h13572468, 32'h9ABCDEF0);
        follow(1'b1, 32'h13572468, 32'h9ABCDEF0, 32'h0, 0, 0, 10, "b2b_wr",
               1'b1, 1'b0, 32'h0000BEEF, 32'h0);
        start_req(1'b0, 32'h0000BEEF, 32'h0);
        follow(1'b0, 32'h0000BEEF, 32'h0, 32'h44332211, 0, 0, 11, "b2b_rd",
               1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during write DATA beat 2 aborts the frame.
        pad_wait_i = 1'b0;
        start_req(1'b1, 32'hDEADBEEF, 32'h12345678);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("rst_pre_beat2", 64'({pad_data_o, pad_data_oe}), 64'({8'h34, 8'hFF}));
        #2 rst_n = 1'b0;
        #1;
        last_rdata = '0;
        check("rst_async",
              64'({pad_addr_o, pad_data_o, pad_data_oe, rsp_valid, req_ready, rsp_rdata}),
              64'({8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 32'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            seen |= rsp_valid;
            @(negedge clk);
        end
        check("rst_no_rsp", 64'(seen), 64'd0);
        run_txn(1'b0, 32'h00000010, 32'h0, 32'hDDCCBBAA, 0, 0, 11, "post_rst_rd");

        for (int i = 0; i < 20; i++) begin
            we = 1'($urandom);
            wl = $urandom_range(3, 0);
            run_txn(we, $urandom, $urandom, $urandom, $urandom_range(DB - 1, 0), wl,
                    (we ? AB + DB + 2 : AB + DB + 3) + (WAIT_ON ? wl : 0),
                    $sformatf("rnd%0d", i));
        end

        // 16-bit address/data instance.
        check("w16_ready", 64'(r16_ready), 64'd1);
        r16_valid = 1'b1;
        r16_we    = 1'b1;
        r16_addr  = 16'hA5C3;
        r16_wdata = 16'h0F1E;
        @(posedge clk);
        @(negedge clk);
        r16_valid = 1'b0;
        r16_addr  = 16'h1111;
        r16_wdata = 16'h2222;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("w16_c%0d", c + 1), 64'({r16_pa, r16_pd, r16_oe, r16_rsp}), 64'(exp16[c]));
            @(negedge clk);
        end
        check("w16_end", 64'({r16_ready, r16_rsp}), 64'({1'b1, 1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
